// File: rtl/hll_result_tx.sv
// Byte-serial HyperLogLog result transmitter: header, 16-bit estimate, every sketch register.
// Define HLL_TX_CHECKSUM_EN to append an XOR checksum byte to each frame.
module hll_result_tx #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned REG_W    = 5,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [15:0]                 estimate_i,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr_o,
  input  logic [REG_W-1:0]            reg_data_i,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 1);

`ifdef HLL_TX_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr, StEstHi, StEstLo, StRd, StReg, StCsum} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StEstHi, StEstLo, StRd, StReg} state_e;
`endif

  state_e        state_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] reg_addr_q;
  logic [AW-1:0] idx_q;
  logic [15:0]   est_q;
  logic          hs;
`ifdef HLL_TX_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  assign hs = tx_valid_q && tx_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reg_addr_q <= '0;
      idx_q      <= '0;
      est_q      <= 16'h0000;
`ifdef HLL_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            est_q      <= estimate_i;
            idx_q      <= '0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StHdr;
`ifdef HLL_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
          end
        end
        StHdr: begin
          if (hs) begin
            tx_data_q <= est_q[15:8];
            state_q   <= StEstHi;
`ifdef HLL_TX_CHECKSUM_EN
            csum_q    <= csum_q ^ tx_data_q;
`endif
          end
        end
        StEstHi: begin
          if (hs) begin
            tx_data_q <= est_q[7:0];
            state_q   <= StEstLo;
`ifdef HLL_TX_CHECKSUM_EN
            csum_q    <= csum_q ^ tx_data_q;
`endif
          end
        end
        StEstLo: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            idx_q      <= '0;
            reg_addr_q <= '0;
            state_q    <= StRd;
`ifdef HLL_TX_CHECKSUM_EN
            csum_q     <= csum_q ^ tx_data_q;
`endif
          end
        end
        StRd: begin
          // Held in tx_data_q so later read-data changes cannot disturb the byte.
          tx_data_q  <= 8'(reg_data_i);
          tx_valid_q <= 1'b1;
          state_q    <= StReg;
        end
        StReg: begin
          if (hs) begin
`ifdef HLL_TX_CHECKSUM_EN
            csum_q <= csum_q ^ tx_data_q;
`endif
            if (idx_q != LastIdx) begin
              idx_q      <= idx_q + AW'(1);
              reg_addr_q <= idx_q + AW'(1);
              tx_valid_q <= 1'b0;
              state_q    <= StRd;
            end else begin
`ifdef HLL_TX_CHECKSUM_EN
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= StCsum;
`else
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StIdle;
`endif
            end
          end
        end
`ifdef HLL_TX_CHECKSUM_EN
        StCsum: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reg_addr_o = reg_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
